// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversample ratio and the
// divider-width helper used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int TICK_W     = $clog2(OVERSAMPLE);

    // Counter width able to hold 0..div-1; never narrower than one bit.
    function automatic int clkdiv_w(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..CLK_DIV-1 and flags the last count.
// Synchronous clear holds the count at zero; shared with the receive path.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int W = clkdiv_w(CLK_DIV);

    logic [W-1:0] cnt_q, cnt_d;
    logic         at_top;

    assign at_top = (cnt_q == W'(CLK_DIV - 1));
    assign tick_o = at_top && !clr_i;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || at_top) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_BITS data (LSB first), optional parity,
// STOP_BITS stop bits. Parity is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_dout,
    output logic                 tx_busy,
    output logic                 tx_done
);

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [2:0]           bit_cnt_q;
    logic [TICK_W-1:0]    tick_cnt_q;
    logic                 dout_q, ready_q, busy_q, done_q;
    logic                 tick, bit_end, idle;
`ifdef UART_TX_PARITY_EN
    logic                 par_q;
`endif

    assign idle    = (state_q == ST_IDLE);
    assign bit_end = tick && (tick_cnt_q == TICK_W'(OVERSAMPLE - 1));

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (idle),
        .tick_o (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            tick_cnt_q <= '0;
            dout_q     <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (idle)      tick_cnt_q <= '0;
            else if (tick) tick_cnt_q <= tick_cnt_q + 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (tx_valid && ready_q) begin
                        shift_q <= tx_data;
`ifdef UART_TX_PARITY_EN
                        par_q   <= (^tx_data) ^ PARITY_ODD[0];
`endif
                        state_q <= ST_START;
                        dout_q  <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_q   <= ST_DATA;
                        dout_q    <= shift_q[0];
                        bit_cnt_q <= '0;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                            bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q   <= ST_PARITY;
                            dout_q    <= par_q;
`else
                            state_q   <= ST_STOP;
                            dout_q    <= 1'b1;
`endif
                        end else begin
                            // Next bit is taken pre-shift so the line and the register move together.
                            shift_q   <= shift_q >> 1;
                            dout_q    <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state_q <= ST_STOP;
                        dout_q  <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    dout_q  <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_dout  = dout_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: instance A is 8N1-style, instance B is
// 5 data / 2 stop with odd parity sense; a 16x receiver model decodes A.
module tb_uart_tx_frame;
    localparam int CD  = 4;
    localparam int BIT = 16 * CD;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a_data;
    logic       a_valid, a_ready, a_dout, a_busy, a_done;
    logic [4:0] b_data;
    logic       b_valid, b_ready, b_dout, b_busy, b_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sel = 0;
    bit rx_on = 1'b0;
    logic [7:0] q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_frame #(.CLK_DIV(CD), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .tx_data(a_data), .tx_valid(a_valid),
        .tx_ready(a_ready), .tx_dout(a_dout), .tx_busy(a_busy), .tx_done(a_done)
    );

    uart_tx_frame #(.CLK_DIV(CD), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_data(b_data), .tx_valid(b_valid),
        .tx_ready(b_ready), .tx_dout(b_dout), .tx_busy(b_busy), .tx_done(b_done)
    );

    wire mon_dout  = (sel != 0) ? b_dout  : a_dout;
    wire mon_ready = (sel != 0) ? b_ready : a_ready;
    wire mon_busy  = (sel != 0) ? b_busy  : a_busy;
    wire mon_done  = (sel != 0) ? b_done  : a_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference 16x receiver on instance A: centre-samples each bit.
    logic [7:0] rx_b;
    logic       rx_p;
    always begin
        @(negedge a_dout);
        if (rx_on) begin
            repeat (BIT / 2) @(negedge clk);
            chk("rx_start", 32'(a_dout), 0);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(negedge clk);
                rx_b[i] = a_dout;
            end
`ifdef UART_TX_PARITY_EN
            repeat (BIT) @(negedge clk);
            rx_p = a_dout;
            chk("rx_parity", 32'(rx_p), 32'(^rx_b));
`endif
            repeat (BIT) @(negedge clk);
            chk("rx_stop", 32'(a_dout), 1);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL rx_unexpected: got %0h expected none", rx_b);
            end else begin
                chk("rx_data", 32'(rx_b), 32'(q.pop_front()));
            end
        end
    end

    // Waits for ready, drives one byte, returns at the negedge of the first start-bit cycle.
    task automatic send(input int s, input logic [7:0] d, output int t0);
        int n = 0;
        @(negedge clk);
        sel = s;
        if (s == 0) begin a_data = d; a_valid = 1'b1; end
        else begin b_data = d[4:0]; b_valid = 1'b1; end
        while (!mon_ready && n < 5000) begin @(negedge clk); n++; end
        chk("send_ready_wait", 32'(n < 5000), 1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk);
        t0 = cyc;
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d, input int nbits,
                               input int nstop, input bit odd, input int t0);
        int nb = 1 + nbits + P + nstop;
        logic e;
        int n = 0;
        chk({tag, "_ready_lo"}, 32'(mon_ready), 0);
        chk({tag, "_busy_hi"}, 32'(mon_busy), 1);
        repeat (BIT / 2) @(negedge clk);
        for (int k = 0; k < nb; k++) begin
            if (k == 0)            e = 1'b0;
            else if (k <= nbits)   e = d[k-1];
            else if (k == nbits + 1 && P == 1) begin
                e = odd;
                for (int j = 0; j < nbits; j++) e = e ^ d[j];
            end
            else                   e = 1'b1;
            chk($sformatf("%s_bit%0d", tag, k), 32'(mon_dout), 32'(e));
            if (k != nb - 1) repeat (BIT) @(negedge clk);
        end
        while (!mon_done && n < BIT) begin @(negedge clk); n++; end
        chk({tag, "_frame_len"}, 32'(cyc - t0), 32'(nb * BIT));
        chk({tag, "_ready_back"}, 32'(mon_ready), 1);
        chk({tag, "_busy_clear"}, 32'(mon_busy), 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(mon_done), 0);
    endtask

    initial begin
        int t0, td, n;
        bit bad;
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        @(negedge clk);
        chk("rst_dout", 32'(a_dout), 1);
        chk("rst_ready", 32'(a_ready), 1);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_done", 32'(a_done), 0);
        bad = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (a_dout !== 1'b1 || a_ready !== 1'b1 || a_busy !== 1'b0 || a_done !== 1'b0 ||
                b_dout !== 1'b1 || b_ready !== 1'b1 || b_busy !== 1'b0 || b_done !== 1'b0)
                bad = 1'b1;
        end
        chk("idle_hold_1000", 32'(bad), 0);
        rx_on = 1'b1;

        // 0xA5 on A; tx_data scrambled mid-frame
        q.push_back(8'hA5);
        send(0, 8'hA5, t0);
        chk("a5_start_low", 32'(a_dout), 0);
        a_data = 8'h00;
        check_frame("a5", 8'hA5, 8, 1, 1'b0, t0);

        // Back-to-back 0x55 then 0xAA with tx_valid held high
        @(negedge clk);
        sel = 0;
        q.push_back(8'h55);
        q.push_back(8'hAA);
        a_data = 8'h55; a_valid = 1'b1;
        chk("b2b_ready", 32'(a_ready), 1);
        @(posedge clk);
        #1 a_data = 8'hAA;
        @(negedge clk);
        t0 = cyc;
        n = 0;
        while (!a_done && n < (10 + P) * BIT + 10) begin @(negedge clk); n++; end
        td = cyc;
        chk("b2b_len1", 32'(td - t0), 32'((10 + P) * BIT));
        chk("b2b_gap_high", 32'(a_dout), 1);
        @(posedge clk);
        #1 a_valid = 1'b0;
        @(negedge clk);
        chk("b2b_start2_low", 32'(a_dout), 0);
        chk("b2b_start2_gap", 32'(cyc - td), 1);
        chk("b2b_busy2", 32'(a_busy), 1);
        t0 = cyc;
        n = 0;
        while (!a_done && n < (10 + P) * BIT + 10) begin @(negedge clk); n++; end
        chk("b2b_len2", 32'(cyc - t0), 32'((10 + P) * BIT));

        // 5 data / 2 stop on B; tx_data changed mid-frame
        send(1, 8'h1F, t0);
        b_data = 5'h00;
        check_frame("b1f", 8'h1F, 5, 2, 1'b1, t0);
        send(1, 8'h0A, t0);
        b_data = 5'h1F;
        check_frame("b0a", 8'h0A, 5, 2, 1'b1, t0);

`ifdef UART_TX_PARITY_EN
        q.push_back(8'h07);
        send(0, 8'h07, t0);
        check_frame("par_even", 8'h07, 8, 1, 1'b0, t0);
        send(1, 8'h07, t0);
        check_frame("par_odd", 8'h07, 5, 2, 1'b1, t0);
`endif

        // Reset during data bit 3 of 0xFF
        rx_on = 1'b0;
        send(0, 8'hFF, t0);
        repeat (4 * BIT + BIT / 2) @(negedge clk);
        chk("rstmid_busy_before", 32'(a_busy), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_dout", 32'(a_dout), 1);
        chk("rstmid_ready", 32'(a_ready), 1);
        chk("rstmid_busy", 32'(a_busy), 0);
        chk("rstmid_done", 32'(a_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 12 * BIT; i++) begin
            @(negedge clk);
            if (a_done !== 1'b0 || a_ready !== 1'b1 || a_busy !== 1'b0 || a_dout !== 1'b1) bad = 1'b1;
        end
        chk("rstmid_stays_idle", 32'(bad), 0);
        rx_on = 1'b1;

        // Clean frame after the aborted one
        q.push_back(8'h3C);
        send(0, 8'h3C, t0);
        check_frame("post_rst", 8'h3C, 8, 1, 1'b0, t0);
        repeat (10) @(negedge clk);
        chk("rx_queue_empty", 32'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

UART transmitter that serialises parallel bytes into asynchronous frames: one start bit, DATA_BITS data bits LSB first, an optional parity bit, and STOP_BITS stop bits. It is the transmit-side counterpart of the 16x-oversampling receive path. It uses the same 16-ticks-per-bit timebase, so a receiver running with equal CLK_DIV centre-samples its frames. It sits between a byte-stream producer (valid/ready) and the serial pin.

## Interface
- CLK_DIV, 4: clk cycles per oversample tick; one bit period = 16*CLK_DIV clk cycles; legal range 1..65535.
- DATA_BITS, 8: data bits per frame; legal range 5..8.
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2.
- PARITY_ODD, 0: parity sense when parity is compiled in; 0 = even, 1 = odd.

- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_data  input  DATA_BITS  byte to send; sampled on accept.
- tx_valid  input  1  producer has a byte.
- tx_ready  output  1  block can accept; reset 1.
- tx_dout  output  1  serial line, idle high; reset 1.
- tx_busy  output  1  frame in progress; reset 0.
- tx_done  output  1  one-cycle pulse at end of last stop bit; reset 0.

## Operation
- Accept occurs on a clk edge with tx_valid=1 and tx_ready=1. On accept, tx_data latches into the shift register, the divider and tick counter clear, and the FSM leaves IDLE.
- FSM states: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
- IDLE: tx_dout=1, tx_ready=1, tx_busy=0.
- START: tx_dout=0 for one bit period.
- DATA: tx_dout = shift[0]; shift right after each bit period; a bit counter runs 0..DATA_BITS-1.
- PARITY: only when compiled in. Drives XOR of the latched data bits, XOR PARITY_ODD.
- STOP: tx_dout=1 for STOP_BITS bit periods.
- Bit timing: the divider counts 0..CLK_DIV-1 and emits a tick at CLK_DIV-1. The tick counter counts 0..15 on ticks. The bit period ends on the tick where the tick counter is at 15.
- tx_data and tx_valid are ignored while tx_ready=0; tx_data changes mid-frame have no effect.
- tx_valid may assert in any cycle. No acceptance occurs without tx_ready.
- Reset mid-frame immediately forces all outputs to their reset values (tx_dout=1, a valid idle level), clears the FSM to IDLE, and discards the byte.

## Timing
- tx_ready falls and tx_busy rises in the cycle after accept. tx_dout goes low (start bit) in that same cycle.
- Each bit lasts exactly 16*CLK_DIV cycles.
- Frame length = (1 + DATA_BITS + P + STOP_BITS)*16*CLK_DIV cycles, where P = 1 if parity is compiled in, else 0.
- Last stop-bit cycle: the following edge asserts tx_done for 1 cycle, sets tx_ready=1 and tx_busy=0.
- Back-to-back: if tx_valid=1 while tx_done=1, that edge accepts. The next start bit begins in the following cycle, so the line holds high for exactly STOP_BITS bit periods plus one clk between frames.
- Divider and tick counter are held at 0 in IDLE. There is no fractional drift across frames.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state is present and frames carry a parity bit per PARITY_ODD.
- UART_TX_PARITY_EN undefined: no PARITY state and no parity logic; DATA goes directly to STOP; PARITY_ODD is ignored.

## Structure
- Shared package uart_pkg holds:
  - the FSM state typedef (ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP);
  - OVERSAMPLE=16;
  - the width-of-CLK_DIV helper function.
- Sub-module uart_baud_tick: CLK_DIV divider with synchronous clear and a tick output. It is reusable by the receive path.

## Test plan
- Reset release with tx_valid=0 -> tx_dout=1, tx_ready=1, tx_busy=0, tx_done=0 held for 1000 cycles.
- Data 0xA5, CLK_DIV=4, no parity -> line reads 0,1,0,1,0,0,1,0,1,1, each bit 64 cycles. tx_done pulses exactly 640 cycles after the first start-bit cycle.
- With UART_TX_PARITY_EN:
  - PARITY_ODD=0, data 0x07 -> parity bit 1.
  - PARITY_ODD=1, data 0x07 -> parity bit 0.
  - Frame is 704 cycles.
- tx_valid held high with 0x55 then 0xAA -> second start bit begins one clk after tx_done. Both bytes decode correctly via a reference 16x-oversampling receiver model.
- Assert rst_n low during data bit 3 of 0xFF -> tx_dout=1 asynchronously. After release: IDLE, tx_ready=1, no tx_done pulse.
- STOP_BITS=2, DATA_BITS=5, data 0x1F -> 1 start + 5 data + 2 stop bits = 8*64 cycles. A tx_data change mid-frame does not alter the transmitted bits.
